// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline registers: control bundle layout
// and the all-zero bubble encoding.
package mips_pipe_pkg;

  localparam int CTRL_W     = 14;
  localparam int CTRL_MEMRD = 5;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 14'b0;

  // Field order mirrors the bit indices BNE=13 down to JUMP=0.
  typedef struct packed {
    logic       bne;
    logic       beq;
    logic [2:0] aluop;
    logic       alusrc;
    logic       regwr;
    logic       memwr;
    logic       memrd;
    logic       memtoreg;
    logic       shamtsel;
    logic       regorpc;
    logic       alumemorpc;
    logic       jump;
  } ctrl_t;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detection between the instruction in EX and
// the one in ID; kept standalone so a forwarding unit can share it.
module load_use_detector (
  input  logic       ex_valid_i,
  input  logic       ex_memrd_i,
  input  logic [4:0] ex_wr_reg_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       flush_i,
  output logic       hazard_o
);

  logic dest_nonzero_s;
  logic src_match_s;

  // $0 is hardwired to zero, so a load into it never creates a dependency.
  always_comb begin
    dest_nonzero_s = (ex_wr_reg_i != 5'd0);
    src_match_s    = (ex_wr_reg_i == id_rs_i) | (ex_wr_reg_i == id_rt_i);
    hazard_o       = ex_valid_i & ex_memrd_i & dest_nonzero_s & src_match_s & ~flush_i;
  end

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use bubble insertion, flush, external
// hold and a saturating bubble counter.
module id_ex_stage_register
  import mips_pipe_pkg::*;
#(
  parameter int NBits    = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Stall,
  input  logic                Flush,
  input  logic [CTRL_W-1:0]   ID_Control,
  input  logic [NBits-1:0]    ID_PCPlus4,
  input  logic [NBits-1:0]    ID_ReadData1,
  input  logic [NBits-1:0]    ID_ReadData2,
  input  logic [NBits-1:0]    ID_InmmediateExtend,
  input  logic [NBits-1:0]    ID_ShamtExtend,
  input  logic [4:0]          ID_Rs,
  input  logic [4:0]          ID_Rt,
  input  logic [4:0]          ID_WriteRegister,
  output logic [CTRL_W-1:0]   EX_Control,
  output logic [NBits-1:0]    EX_PCPlus4,
  output logic [NBits-1:0]    EX_ReadData1,
  output logic [NBits-1:0]    EX_ReadData2,
  output logic [NBits-1:0]    EX_InmmediateExtend,
  output logic [NBits-1:0]    EX_ShamtExtend,
  output logic [4:0]          EX_Rs,
  output logic [4:0]          EX_Rt,
  output logic [4:0]          EX_WriteRegister,
  output logic                EX_Valid,
  output logic                HazardStall,
  output logic [CNT_BITS-1:0] BubbleCount
);

  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [NBits-1:0]    pc_q, pc_d;
  logic [NBits-1:0]    rd1_q, rd1_d;
  logic [NBits-1:0]    rd2_q, rd2_d;
  logic [NBits-1:0]    imm_q, imm_d;
  logic [NBits-1:0]    shamt_q, shamt_d;
  logic [4:0]          rs_q, rs_d;
  logic [4:0]          rt_q, rt_d;
  logic [4:0]          wr_q, wr_d;
  logic                valid_q, valid_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                hazard_s;
  logic                bubble_s;

  load_use_detector u_load_use_detector (
    .ex_valid_i  (valid_q),
    .ex_memrd_i  (ctrl_q[CTRL_MEMRD]),
    .ex_wr_reg_i (wr_q),
    .id_rs_i     (ID_Rs),
    .id_rt_i     (ID_Rt),
    .flush_i     (Flush),
    .hazard_o    (hazard_s)
  );

  // A bubble is loaded on flush, or on a hazard that is not masked by a hold.
  always_comb begin
    bubble_s = Flush | (~Stall & hazard_s);
  end

  // Next-state selection: flush > stall > hazard > normal capture.
  always_comb begin
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    shamt_d = shamt_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wr_d    = wr_q;
    valid_d = valid_q;
    if (Stall && !Flush) begin
      valid_d = valid_q;
    end else if (bubble_s) begin
      ctrl_d  = CTRL_BUBBLE;
      pc_d    = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      shamt_d = '0;
      rs_d    = 5'd0;
      rt_d    = 5'd0;
      wr_d    = 5'd0;
      valid_d = 1'b0;
    end else begin
      ctrl_d  = ID_Control;
      pc_d    = ID_PCPlus4;
      rd1_d   = ID_ReadData1;
      rd2_d   = ID_ReadData2;
      imm_d   = ID_InmmediateExtend;
      shamt_d = ID_ShamtExtend;
      rs_d    = ID_Rs;
      rt_d    = ID_Rt;
      wr_d    = ID_WriteRegister;
      valid_d = 1'b1;
    end
  end

  // Pipeline state; reset leaves a bubble in EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= CTRL_BUBBLE;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      shamt_q <= '0;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      wr_q    <= 5'd0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      shamt_q <= shamt_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wr_q    <= wr_d;
      valid_q <= valid_d;
    end
  end

  // Saturating bubble counter.
  always_comb begin
    if (bubble_s && (cnt_q != {CNT_BITS{1'b1}})) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign EX_Control          = ctrl_q;
  assign EX_PCPlus4          = pc_q;
  assign EX_ReadData1        = rd1_q;
  assign EX_ReadData2        = rd2_q;
  assign EX_InmmediateExtend = imm_q;
  assign EX_ShamtExtend      = shamt_q;
  assign EX_Rs               = rs_q;
  assign EX_Rt               = rt_q;
  assign EX_WriteRegister    = wr_q;
  assign EX_Valid            = valid_q;
  assign HazardStall         = hazard_s;
  assign BubbleCount         = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed table-driven bench for id_ex_stage_register, plus hand-written
// reset and counter-saturation sequences.
module tb_id_ex_stage_register;

  localparam int NB = 32;
  localparam int CB = 16;

  logic            clk;
  logic            reset;
  logic            Stall;
  logic            Flush;
  logic [13:0]     ID_Control;
  logic [NB-1:0]   ID_PCPlus4, ID_ReadData1, ID_ReadData2, ID_InmmediateExtend, ID_ShamtExtend;
  logic [4:0]      ID_Rs, ID_Rt, ID_WriteRegister;
  logic [13:0]     EX_Control;
  logic [NB-1:0]   EX_PCPlus4, EX_ReadData1, EX_ReadData2, EX_InmmediateExtend, EX_ShamtExtend;
  logic [4:0]      EX_Rs, EX_Rt, EX_WriteRegister;
  logic            EX_Valid;
  logic            HazardStall;
  logic [CB-1:0]   BubbleCount;

  int tests_run;
  int tests_failed;

  id_ex_stage_register #(.NBits(NB), .CNT_BITS(CB)) dut (
    .clk                 (clk),
    .reset               (reset),
    .Stall               (Stall),
    .Flush               (Flush),
    .ID_Control          (ID_Control),
    .ID_PCPlus4          (ID_PCPlus4),
    .ID_ReadData1        (ID_ReadData1),
    .ID_ReadData2        (ID_ReadData2),
    .ID_InmmediateExtend (ID_InmmediateExtend),
    .ID_ShamtExtend      (ID_ShamtExtend),
    .ID_Rs               (ID_Rs),
    .ID_Rt               (ID_Rt),
    .ID_WriteRegister    (ID_WriteRegister),
    .EX_Control          (EX_Control),
    .EX_PCPlus4          (EX_PCPlus4),
    .EX_ReadData1        (EX_ReadData1),
    .EX_ReadData2        (EX_ReadData2),
    .EX_InmmediateExtend (EX_InmmediateExtend),
    .EX_ShamtExtend      (EX_ShamtExtend),
    .EX_Rs               (EX_Rs),
    .EX_Rt               (EX_Rt),
    .EX_WriteRegister    (EX_WriteRegister),
    .EX_Valid            (EX_Valid),
    .HazardStall         (HazardStall),
    .BubbleCount         (BubbleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [13:0] ctrl;
    logic [4:0]  rs, rt, wr;
    logic [31:0] pc;
    logic        exp_hz;
    logic [13:0] exp_ctrl;
    logic        exp_valid;
    logic [4:0]  exp_rs, exp_rt, exp_wr;
    logic [31:0] exp_pc;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Data operands are derived from PC+4 so one field checks all five buses.
  task automatic drive(input logic st, input logic fl, input logic [13:0] c,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                       input logic [31:0] pc);
    Stall               = st;
    Flush               = fl;
    ID_Control          = c;
    ID_Rs               = rs;
    ID_Rt               = rt;
    ID_WriteRegister    = wr;
    ID_PCPlus4          = pc;
    ID_ReadData1        = pc + 32'd1;
    ID_ReadData2        = pc + 32'd2;
    ID_InmmediateExtend = pc + 32'd3;
    ID_ShamtExtend      = pc + 32'd4;
  endtask

  function automatic logic [159:0] exp_data(input logic [31:0] pc, input logic valid);
    if (!valid) return 160'd0;
    return {pc, pc + 32'd1, pc + 32'd2, pc + 32'd3, pc + 32'd4};
  endfunction

  function automatic logic [159:0] act_data();
    return {EX_PCPlus4, EX_ReadData1, EX_ReadData2, EX_InmmediateExtend, EX_ShamtExtend};
  endfunction

  function automatic vec_t mk(input logic st, input logic fl, input logic [13:0] c,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                              input logic [31:0] pc, input logic hz,
                              input logic [13:0] ec, input logic ev, input logic [4:0] ers,
                              input logic [4:0] ert, input logic [4:0] ewr,
                              input logic [31:0] epc, input logic [15:0] ecnt);
    vec_t v;
    v.stall = st; v.flush = fl; v.ctrl = c; v.rs = rs; v.rt = rt; v.wr = wr; v.pc = pc;
    v.exp_hz = hz; v.exp_ctrl = ec; v.exp_valid = ev; v.exp_rs = ers; v.exp_rt = ert;
    v.exp_wr = ewr; v.exp_pc = epc; v.exp_cnt = ecnt;
    return v;
  endfunction

  localparam logic [13:0] LW  = 14'h1B0;
  localparam logic [13:0] ADD = 14'h480;
  localparam logic [13:0] C0A3 = 14'h0A3;

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //          st    fl    ctrl  rs     rt     wr     pc          hz    ectrl ev    ers    ert    ewr    epc         ecnt
    vecs.push_back(mk(1'b0, 1'b0, LW,   5'd9,  5'd8,  5'd8,  32'h100, 1'b0, LW,   1'b1, 5'd9,  5'd8,  5'd8,  32'h100, 16'd0));
    vecs.push_back(mk(1'b0, 1'b0, ADD,  5'd8,  5'd11, 5'd10, 32'h104, 1'b1, 14'd0,1'b0, 5'd0,  5'd0,  5'd0,  32'h0,   16'd1));
    vecs.push_back(mk(1'b0, 1'b0, ADD,  5'd8,  5'd11, 5'd10, 32'h104, 1'b0, ADD,  1'b1, 5'd8,  5'd11, 5'd10, 32'h104, 16'd1));
    vecs.push_back(mk(1'b0, 1'b0, LW,   5'd9,  5'd0,  5'd0,  32'h108, 1'b0, LW,   1'b1, 5'd9,  5'd0,  5'd0,  32'h108, 16'd1));
    vecs.push_back(mk(1'b0, 1'b0, ADD,  5'd0,  5'd11, 5'd10, 32'h10C, 1'b0, ADD,  1'b1, 5'd0,  5'd11, 5'd10, 32'h10C, 16'd1));
    vecs.push_back(mk(1'b0, 1'b1, C0A3, 5'd3,  5'd4,  5'd5,  32'h110, 1'b0, 14'd0,1'b0, 5'd0,  5'd0,  5'd0,  32'h0,   16'd2));
    vecs.push_back(mk(1'b0, 1'b0, C0A3, 5'd3,  5'd4,  5'd5,  32'h114, 1'b0, C0A3, 1'b1, 5'd3,  5'd4,  5'd5,  32'h114, 16'd2));
    vecs.push_back(mk(1'b1, 1'b0, LW,   5'd5,  5'd5,  5'd7,  32'h118, 1'b1, C0A3, 1'b1, 5'd3,  5'd4,  5'd5,  32'h114, 16'd2));
    vecs.push_back(mk(1'b1, 1'b0, ADD,  5'd6,  5'd5,  5'd9,  32'h11C, 1'b1, C0A3, 1'b1, 5'd3,  5'd4,  5'd5,  32'h114, 16'd2));
    vecs.push_back(mk(1'b1, 1'b0, LW,   5'd1,  5'd2,  5'd3,  32'h120, 1'b0, C0A3, 1'b1, 5'd3,  5'd4,  5'd5,  32'h114, 16'd2));
    vecs.push_back(mk(1'b1, 1'b1, LW,   5'd5,  5'd5,  5'd7,  32'h124, 1'b0, 14'd0,1'b0, 5'd0,  5'd0,  5'd0,  32'h0,   16'd3));
    vecs.push_back(mk(1'b0, 1'b0, LW,   5'd9,  5'd0,  5'd8,  32'h200, 1'b0, LW,   1'b1, 5'd9,  5'd0,  5'd8,  32'h200, 16'd3));
    vecs.push_back(mk(1'b0, 1'b0, ADD,  5'd2,  5'd8,  5'd10, 32'h204, 1'b1, 14'd0,1'b0, 5'd0,  5'd0,  5'd0,  32'h0,   16'd4));
    vecs.push_back(mk(1'b0, 1'b0, ADD,  5'd2,  5'd8,  5'd10, 32'h204, 1'b0, ADD,  1'b1, 5'd2,  5'd8,  5'd10, 32'h204, 16'd4));

    reset = 1'b1;
    drive(1'b0, 1'b0, 14'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    #1;
    chk("reset_ctrl",  {146'd0, EX_Control}, 160'd0);
    chk("reset_valid", {159'd0, EX_Valid}, 160'd0);
    chk("reset_data",  act_data(), 160'd0);
    chk("reset_cnt",   {144'd0, BubbleCount}, 160'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].wr, vecs[i].pc);
      #1;
      chk($sformatf("v%0d_hazard", i), {159'd0, HazardStall}, {159'd0, vecs[i].exp_hz});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ctrl", i), {145'd0, EX_Valid, EX_Control}, {145'd0, vecs[i].exp_valid, vecs[i].exp_ctrl});
      chk($sformatf("v%0d_regs", i), {145'd0, EX_Rs, EX_Rt, EX_WriteRegister},
          {145'd0, vecs[i].exp_rs, vecs[i].exp_rt, vecs[i].exp_wr});
      chk($sformatf("v%0d_data", i), act_data(), exp_data(vecs[i].exp_pc, vecs[i].exp_valid));
      chk($sformatf("v%0d_cnt", i), {144'd0, BubbleCount}, {144'd0, vecs[i].exp_cnt});
      @(negedge clk);
    end

    // Reset pulsed mid-stall with a live hazard must clear everything at once.
    drive(1'b0, 1'b0, LW, 5'd9, 5'd0, 5'd8, 32'h300);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, ADD, 5'd8, 5'd8, 5'd10, 32'h304);
    #1;
    chk("pre_reset_hazard", {159'd0, HazardStall}, {159'd0, 1'b1});
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_ctrl",  {145'd0, EX_Valid, EX_Control}, 160'd0);
    chk("midrst_data",  act_data(), 160'd0);
    chk("midrst_regs",  {145'd0, EX_Rs, EX_Rt, EX_WriteRegister}, 160'd0);
    chk("midrst_cnt",   {144'd0, BubbleCount}, 160'd0);
    chk("midrst_hazard",{159'd0, HazardStall}, 160'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, C0A3, 5'd3, 5'd4, 5'd5, 32'h400);
    @(posedge clk);
    #1;
    chk("postrst_ctrl", {145'd0, EX_Valid, EX_Control}, {145'd0, 1'b1, C0A3});
    chk("postrst_data", act_data(), exp_data(32'h400, 1'b1));
    chk("postrst_cnt",  {144'd0, BubbleCount}, 160'd0);

    // Counter saturation: continuous flushes.
    @(negedge clk);
    drive(1'b0, 1'b1, C0A3, 5'd3, 5'd4, 5'd5, 32'h500);
    for (int k = 0; k < 65534; k++) @(posedge clk);
    #1;
    chk("sat_fffe", {144'd0, BubbleCount}, {144'd0, 16'hFFFE});
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("sat_65536", {144'd0, BubbleCount}, {144'd0, 16'hFFFF});
    for (int k = 0; k < 3; k++) @(posedge clk);
    #1;
    chk("sat_hold", {144'd0, BubbleCount}, {144'd0, 16'hFFFF});
    chk("sat_bubble", {145'd0, EX_Valid, EX_Control}, 160'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
